sample_oscillator_bank: RTL
===========================

// Module: sample_oscillator_bank
// PURPOSE
//  - Multi-voice audio source clocked by clock_16_934_400; replaces the fixed single sawtooth at the top of conFFTi.
//  - Produces a one-cycle sample strobe at AUDIO_SAMPLE_RATE from a tick counter; no derived clock.
//  - NUM_VOICES phase-accumulator oscillators (saw/square/triangle) are updated once per sample and mixed
//    into one signed sample with a valid pulse. Voices are written through a simple config port.
// PARAMETERS
//  NUM_VOICES      4     oscillator count, >=2, power of two
//  PHASE_WIDTH     32    phase accumulator width, >= AUDIO_BIT_WIDTH+1
//  AUDIO_BIT_WIDTH 24    output sample width (default CONFIG::AUDIO_BIT_WIDTH)
//  SAMPLE_TICKS    384   clocks per sample (CONFIG::AUDIO_CLOCK/CONFIG::AUDIO_SAMPLE_RATE); must exceed NUM_VOICES+3
// PORTS
//  clock_16_934_400 in  1                    audio clock, all logic on posedge
//  reset_l          in  1                    asynchronous, active-low reset
//  cfg_wr           in  1                    write strobe, one voice per cycle
//  cfg_voice        in  $clog2(NUM_VOICES)   target voice index
//  cfg_on           in  1                    voice enable
//  cfg_wave         in  2                    00 saw, 01 square, 10 triangle, 11 silent
//  cfg_phase_inc    in  PHASE_WIDTH          phase increment per sample
//  sample_strobe    out 1                    1-cycle pulse at each sample boundary
//  audio_out        out AUDIO_BIT_WIDTH      signed two's-complement mixed sample
//  audio_valid      out 1                    1-cycle pulse when audio_out updates
// BEHAVIOUR
//  - Reset (async): tick counter 0, all voice regs 0 (off, saw, inc 0, phase 0), FSM IDLE, acc 0,
//    sample_strobe 0, audio_out 0, audio_valid 0. A reset mid-frame abandons the frame with no valid pulse.
//  - Tick counter: counts 0..SAMPLE_TICKS-1 and wraps to 0. sample_strobe=1 in the cycle count==SAMPLE_TICKS-1.
//  - FSM IDLE: on sample_strobe, go to ACCUM with voice index v=0 and acc=0.
//  - FSM ACCUM: one voice per cycle. acc += wave(v), then phase[v] += inc[v] (mod 2^PHASE_WIDTH) if the voice
//    is on. At v==NUM_VOICES-1, go to SCALE.
//  - FSM SCALE: register the mixed result into audio_out, pulse audio_valid, return to IDLE.
//  - Latency: audio_valid is high NUM_VOICES+2 cycles after sample_strobe. audio_out holds between pulses.
//  - The waveform uses the phase before the increment, so the first sample after enable uses phase 0.
//  - Waveforms: let p = phase[PW-1 -: W+1], W=AUDIO_BIT_WIDTH.
//      saw:    {~p[W], p[W-1:1]}
//      square: p[W] ? -2^(W-1) : 2^(W-1)-1
//      tri:    f = p[W] ? ~p[W-1:0] : p[W-1:0], output {~f[W-1], f[W-2:0]}
//      silent / off voice: 0
//  - acc is signed, W+$clog2(NUM_VOICES) bits wide, so the sum never overflows.
//  - Config write: cfg_wr updates on/wave/inc of cfg_voice at the clock edge.
//      - A write to the voice being processed in the same cycle: processing uses the old values,
//        and the new values hold from the next cycle.
//      - Writing cfg_on=0 also clears phase[cfg_voice] to 0; the clear takes priority over the ACCUM increment.
//      - An off voice holds phase 0.
//  - sample_strobe is never masked. The FSM is always IDLE at a strobe because of the SAMPLE_TICKS constraint.
// CONFIGURATION
//  - CONFFTI_SAT_MIX_EN defined: audio_out = acc clamped to [-2^(W-1), 2^(W-1)-1] (no attenuation).
//  - Not defined: audio_out = acc >>> $clog2(NUM_VOICES) (arithmetic shift; always in range, never clips).
// STRUCTURE
//  - CONFIG package gains:
//      - typedef enum logic [1:0] wave_t {WAVE_SAW, WAVE_SQUARE, WAVE_TRI, WAVE_OFF}
//      - typedef struct packed voice_cfg_t {on, wave, phase_inc}
//      - localparam SAMPLE_TICKS
//  - One sub-module, oscillator_wave: combinational phase+wave_t -> signed W-bit sample, shared by the single ACCUM datapath.
//  - The tick counter, FSM, voice register file and mixer stay in the top block.
// TESTING (W=24, PW=32, NUM_VOICES=4, SAMPLE_TICKS=384)
//  1. Release reset, no config -> sample_strobe every 384 clocks, audio_valid 6 cycles after each, audio_out 0.
//  2. Voice0 on, saw, inc=2^28; sample k -> audio_out=(k*2^20-2^23)>>>2: k=0 -2097152, k=1 -1835008,
//     k=16 wraps to -2097152.
//  3. All 4 voices square, inc=0 -> audio_out=8388607. With inc=2^31 -> alternates 8388607 / -8388608.
//  4. Voices 0,1 square inc=0, others off -> 4194303; with CONFFTI_SAT_MIX_EN -> 8388607 (clamped).
//  5. cfg_wr cfg_on=0 to voice0 in the cycle voice0 is processed -> that sample uses the old value,
//     the next sample uses 0 and phase0=0.
//  6. Assert reset_l low during ACCUM -> all outputs 0 immediately, no audio_valid, strobe resumes 384 clocks after release.

Source files
------------

// File: rtl/sample_oscillator_bank_pkg.sv
// Shared types and default sizing for the conFFTi oscillator bank.
// Sample rate derives from the 16.9344 MHz audio clock.
package sample_oscillator_bank_pkg;

    localparam int AUDIO_CLOCK       = 16934400;
    localparam int AUDIO_SAMPLE_RATE = 44100;
    localparam int AUDIO_BIT_WIDTH   = 24;
    localparam int PHASE_WIDTH       = 32;
    localparam int NUM_VOICES        = 4;
    localparam int SAMPLE_TICKS      = AUDIO_CLOCK / AUDIO_SAMPLE_RATE;

    typedef enum logic [1:0] {
        WAVE_SAW,
        WAVE_SQUARE,
        WAVE_TRI,
        WAVE_OFF
    } wave_t;

    typedef struct packed {
        logic                   on;
        wave_t                  wave;
        logic [PHASE_WIDTH-1:0] phase_inc;
    } voice_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE
    } state_t;

endpackage

// File: rtl/sample_oscillator_bank_if.sv
// Voice config port plus mixed audio output of the oscillator bank.
// The master drives config and consumes samples; the bank is the slave.
interface sample_oscillator_bank_if
    import sample_oscillator_bank_pkg::*;
#(
    parameter int NUM_VOICES      = 4,
    parameter int PHASE_WIDTH     = 32,
    parameter int AUDIO_BIT_WIDTH = 24
);
    localparam int VW = $clog2(NUM_VOICES);

    logic                       cfg_wr;
    logic [VW-1:0]              cfg_voice;
    logic                       cfg_on;
    wave_t                      cfg_wave;
    logic [PHASE_WIDTH-1:0]     cfg_phase_inc;
    logic                       sample_strobe;
    logic [AUDIO_BIT_WIDTH-1:0] audio_out;
    logic                       audio_valid;

    modport master (
        output cfg_wr,
        output cfg_voice,
        output cfg_on,
        output cfg_wave,
        output cfg_phase_inc,
        input  sample_strobe,
        input  audio_out,
        input  audio_valid
    );

    modport slave (
        input  cfg_wr,
        input  cfg_voice,
        input  cfg_on,
        input  cfg_wave,
        input  cfg_phase_inc,
        output sample_strobe,
        output audio_out,
        output audio_valid
    );

endinterface

// File: rtl/sample_oscillator_bank_oscillator_wave.sv
// Phase-top-bits to signed sample shaper (saw, square, triangle, silent).
// Purely combinational; shared by every voice through the accumulate path.
module oscillator_wave
    import sample_oscillator_bank_pkg::*;
#(
    parameter int W = AUDIO_BIT_WIDTH
) (
    input  logic [W:0]          p,
    input  wave_t               wave,
    output logic signed [W-1:0] sample
);

    logic [W-1:0] f;

    always_comb begin
        f      = p[W] ? ~p[W-1:0] : p[W-1:0];
        sample = '0;
        unique case (wave)
            WAVE_SAW:    sample = {~p[W], p[W-1:1]};
            WAVE_SQUARE: sample = p[W] ? {1'b1, {(W-1){1'b0}}}
                                       : {1'b0, {(W-1){1'b1}}};
            WAVE_TRI:    sample = {~f[W-1], f[W-2:0]};
            default:     sample = '0;
        endcase
    end

endmodule

// File: rtl/sample_oscillator_bank.sv
// Multi-voice phase-accumulator audio source with sample strobe and mixer.
// Define CONFFTI_SAT_MIX_EN for a clamped mix instead of the shifted one.
module sample_oscillator_bank #(
    parameter int NUM_VOICES      = sample_oscillator_bank_pkg::NUM_VOICES,
    parameter int PHASE_WIDTH     = sample_oscillator_bank_pkg::PHASE_WIDTH,
    parameter int AUDIO_BIT_WIDTH = sample_oscillator_bank_pkg::AUDIO_BIT_WIDTH,
    parameter int SAMPLE_TICKS    = sample_oscillator_bank_pkg::SAMPLE_TICKS
) (
    input logic                     clock_16_934_400,
    input logic                     reset_l,
    sample_oscillator_bank_if.slave bank
);
    import sample_oscillator_bank_pkg::*;

    localparam int W  = AUDIO_BIT_WIDTH;
    localparam int VW = $clog2(NUM_VOICES);
    localparam int AW = W + VW;
    localparam int CW = $clog2(SAMPLE_TICKS);

    localparam logic signed [AW-1:0] MIX_MAX = {{(VW+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIX_MIN = {{(VW+1){1'b1}}, {(W-1){1'b0}}};

    logic [CW-1:0]          tick;
    logic                   strobe_q;
    voice_cfg_t             cfg   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase [NUM_VOICES];
    state_t                 state;
    logic [VW-1:0]          v;
    logic signed [AW-1:0]   acc;
    logic signed [W-1:0]    wave_s;
    logic signed [W-1:0]    voice_s;
    logic signed [W-1:0]    mixed;
    logic signed [W-1:0]    audio_q;
    logic                   valid_q;

    assign bank.sample_strobe = strobe_q;
    assign bank.audio_out     = audio_q;
    assign bank.audio_valid   = valid_q;

    // Strobe registered one count early so it is high while tick is at the end.
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            tick     <= '0;
            strobe_q <= 1'b0;
        end else begin
            tick     <= (tick == CW'(SAMPLE_TICKS - 1)) ? '0 : tick + 1'b1;
            strobe_q <= (tick == CW'(SAMPLE_TICKS - 2));
        end
    end

    oscillator_wave #(
        .W (W)
    ) u_wave (
        .p      (phase[v][PHASE_WIDTH-1 -: W+1]),
        .wave   (cfg[v].wave),
        .sample (wave_s)
    );

    assign voice_s = cfg[v].on ? wave_s : '0;

    always_comb begin
`ifdef CONFFTI_SAT_MIX_EN
        if (acc > MIX_MAX)
            mixed = W'(MIX_MAX);
        else if (acc < MIX_MIN)
            mixed = W'(MIX_MIN);
        else
            mixed = W'(acc);
`else
        mixed = W'(acc >>> VW);
`endif
    end

    // Disabling a voice zeroes its phase, overriding any same-cycle advance.
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                cfg[i]   <= '0;
                phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (bank.cfg_wr && bank.cfg_voice == VW'(i)) begin
                    cfg[i].on        <= bank.cfg_on;
                    cfg[i].wave      <= bank.cfg_wave;
                    cfg[i].phase_inc <= bank.cfg_phase_inc;
                end
                if (bank.cfg_wr && bank.cfg_voice == VW'(i) && !bank.cfg_on)
                    phase[i] <= '0;
                else if (state == ST_ACCUM && v == VW'(i) && cfg[i].on)
                    phase[i] <= phase[i] + cfg[i].phase_inc;
            end
        end
    end

    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            state   <= ST_IDLE;
            v       <= '0;
            acc     <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (strobe_q) begin
                        state <= ST_ACCUM;
                        v     <= '0;
                        acc   <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + {{VW{voice_s[W-1]}}, voice_s};
                    v   <= v + 1'b1;
                    if (v == VW'(NUM_VOICES - 1))
                        state <= ST_SCALE;
                end
                ST_SCALE: begin
                    audio_q <= mixed;
                    valid_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
